// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//
// Round-robin arbiter that shares one valid/ready stream sink among NUM_REQ
// requesters. A requester is granted for a burst that ends on its req_last
// beat or after MAX_BURST beats, whichever comes first. The granted channel is
// passed combinationally to the sink. The next search starts at the requester
// after the one just served. Every pair of grants is separated by one IDLE
// cycle.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   DATA_WIDTH  beat width in bits
//   MAX_BURST   maximum beats per grant (1..255)
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high
//   req_valid        per-requester beat valid
//   req_data         requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last         per-requester final beat of burst
//   req_ready        per-requester accept (only the granted one can be 1)
//   stream_in_valid  beat valid to sink
//   stream_in_data   beat data to sink
//   stream_in_ready  accept from sink
//   grant_id         current or most recent granted requester
//   busy             1 while a grant is active
//   grant_count      (STREAM_RR_ARBITER_STATS_EN only) saturating grant count
//
// Configuration
//   Define STREAM_RR_ARBITER_STATS_EN to add the grant_count output.
// -----------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          stream_in_valid,
    output logic [DATA_WIDTH-1:0]         stream_in_data,
    input  logic                          stream_in_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef STREAM_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]                   grant_count
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      beat_cnt;

    logic [ID_W-1:0] winner;
    logic            win_found;
    logic            sel_valid;
    logic            sel_last;
    logic            beat;
    logic            burst_end;

    // -------------------------------------------------------------------------
    // Round-robin search. Requesters at or above rr_ptr take priority over
    // those below it; within each group the lowest index wins. That is the
    // same as scanning upward from rr_ptr with wrap-around.
    // -------------------------------------------------------------------------
    logic [ID_W-1:0] win_hi;
    logic [ID_W-1:0] win_lo;
    logic            found_hi;
    logic            found_lo;

    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so the block stays purely combinational (no latches).
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        // Scanning downward lets the lowest matching index overwrite last.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (ID_W'(j) >= rr_ptr) begin
                    win_hi   = ID_W'(j);
                    found_hi = 1'b1;
                end else begin
                    win_lo   = ID_W'(j);
                    found_lo = 1'b1;
                end
            end
        end
        winner    = found_hi ? win_hi : win_lo;
        win_found = found_hi | found_lo;
    end

    // -------------------------------------------------------------------------
    // Select the granted channel's signals.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_valid      = 1'b0;
        sel_last       = 1'b0;
        stream_in_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_id == ID_W'(j)) begin
                sel_valid      = req_valid[j];
                sel_last       = req_last[j];
                stream_in_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples pre-edge values regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. Reset gates the handshake outputs at once, even while the
    // state register still shows GRANT.
    // -------------------------------------------------------------------------
    always_comb begin
        stream_in_valid = 1'b0;
        req_ready       = '0;
        if (state == GRANT && !reset) begin
            stream_in_valid = sel_valid;
            for (int j = 0; j < NUM_REQ; j++) begin
                req_ready[j] = (grant_id == ID_W'(j)) & stream_in_ready;
            end
        end
    end

    assign busy = (state == GRANT);

    // A beat with req_last, or the MAX_BURST-th beat, closes the burst. When
    // both conditions hit on the same beat it is still a single burst end.
    assign beat      = stream_in_valid & stream_in_ready;
    assign burst_end = beat & (sel_last | (beat_cnt == 8'(MAX_BURST - 1)));

    // -------------------------------------------------------------------------
    // Grant bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE) begin
                if (win_found) begin
                    grant_id <= winner;
                    beat_cnt <= '0;
                end
            end else begin
                if (beat) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (burst_end) begin
                    rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end

`ifdef STREAM_RR_ARBITER_STATS_EN
    // Counts IDLE->GRANT transitions and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
        end else if (state == IDLE && win_found && grant_count != 16'hFFFF) begin
            grant_count <= grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Bench for stream_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4). Each
// requester is fed from a queue of {last, data} beats. A transaction-level
// model (current owner, next search start, beats served) predicts the DUT
// outputs every cycle. Directed scenarios also check grant order and the beat
// sequence against fixed expectations. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          stream_in_valid;
    logic [DW-1:0] stream_in_data;
    logic          stream_in_ready;
    logic [1:0]    grant_id;
    logic          busy;
`ifdef STREAM_RR_ARBITER_STATS_EN
    logic [15:0]   grant_count;
`endif

    stream_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .stream_in_valid(stream_in_valid),
        .stream_in_data (stream_in_data),
        .stream_in_ready(stream_in_ready),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef STREAM_RR_ARBITER_STATS_EN
        ,
        .grant_count    (grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench state
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0] q [N][$];      // {last, data} per requester
    logic [N-1:0] mute;        // forces req_valid low while a beat is pending

    // Reference model
    int m_owner;               // -1 when no grant is active
    int m_last;                // most recent granted requester
    int m_start;               // where the next search begins
    int m_beats;               // beats served in the current grant
    int m_gcount;

    // Observations from the DUT
    int         obs_grant[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];
    int         busy_cnt;
    logic       prev_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        logic [8:0] head;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                head               = q[i][0];
                req_valid[i]       = !mute[i];
                req_data[i*DW +: DW] = head[7:0];
                req_last[i]        = head[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic          e_valid;
        logic [N-1:0]  e_ready;
        e_valid = !reset && m_owner >= 0 && req_valid[m_owner];
        e_ready = (!reset && m_owner >= 0 && stream_in_ready) ? N'(1 << m_owner) : '0;
        check("busy",      32'(busy),            32'(m_owner >= 0));
        check("grant_id",  32'(grant_id),        32'(m_last));
        check("in_valid",  32'(stream_in_valid), 32'(e_valid));
        check("req_ready", 32'(req_ready),       32'(e_ready));
        if (e_valid) begin
            check("in_data", 32'(stream_in_data), 32'(req_data[m_owner*DW +: DW]));
        end
`ifdef STREAM_RR_ARBITER_STATS_EN
        check("grant_count", 32'(grant_count), 32'(m_gcount));
`endif
    endtask

    task automatic model_clock();
        bit acc [N];
        for (int i = 0; i < N; i++) begin
            acc[i] = !reset && m_owner == i && req_valid[i] && stream_in_ready;
        end
        if (reset) begin
            m_owner  = -1;
            m_last   = 0;
            m_start  = 0;
            m_beats  = 0;
            m_gcount = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_start + k) % N;
                if (req_valid[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_beats = 0;
                    if (m_gcount < 65535) m_gcount++;
                    break;
                end
            end
        end else if (req_valid[m_owner] && stream_in_ready) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_start = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(q[i].pop_front());
        end
    endtask

    // One clock: drive inputs, check at negedge, advance the model at posedge.
    task automatic step();
        drive();
        @(negedge clk);
        check_outputs();
        if (busy && !prev_busy) obs_grant.push_back(int'(grant_id));
        prev_busy = busy;
        if (busy) busy_cnt++;
        if (stream_in_valid && stream_in_ready) begin
            obs_data.push_back(stream_in_data);
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
    endtask

    task automatic clear_logs();
        obs_grant.delete();
        obs_data.delete();
        obs_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) q[i].delete();
        mute            = '0;
        stream_in_ready = 1'b1;
        reset           = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while (!queues_empty() && n < limit) begin
            step();
            n++;
        end
        if (!queues_empty()) check({tag, "_timeout"}, 32'd1, 32'd0);
        step();
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        check({tag, "_ngrant"}, 32'(obs_grant.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_grant.size(); i++) begin
            check($sformatf("%s_grant%0d", tag, i), 32'(obs_grant[i]), 32'(exp[i]));
        end
    endtask

    task automatic check_data(input string tag, input logic [7:0] exp[$]);
        check({tag, "_nbeat"}, 32'(obs_data.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_data.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 32'(obs_data[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        req_valid       = '0;
        req_data        = '0;
        req_last        = '0;
        stream_in_ready = 1'b0;
        mute            = '0;
        reset           = 1'b1;
        prev_busy       = 1'b0;
        m_owner         = -1;
        m_last          = 0;
        m_start         = 0;
        m_beats         = 0;
        m_gcount        = 0;
        busy_cnt        = 0;
        #1;

        // Single requester, 3-beat burst; the following search starts at 3.
        reset_dut();
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        q[2].push_back({1'b0, 8'hA1});
        q[2].push_back({1'b0, 8'hA2});
        q[2].push_back({1'b1, 8'hA3});
        drain("s1", 20);
        check_grants("s1", '{2});
        check_data("s1", '{8'hA1, 8'hA2, 8'hA3});
        check("s1_busy_cycles", 32'(busy_cnt), 32'd3);
        clear_logs();
        q[0].push_back({1'b1, 8'h05});
        q[3].push_back({1'b1, 8'h35});
        drain("s1b", 20);
        check_grants("s1b", '{3, 0});

        // All four valid with 1-beat bursts: order 0,1,2,3,0, beat every 2 cycles.
        reset_dut();
        q[0].push_back({1'b1, 8'h00});
        q[0].push_back({1'b1, 8'h01});
        q[1].push_back({1'b1, 8'h10});
        q[2].push_back({1'b1, 8'h20});
        q[3].push_back({1'b1, 8'h30});
        drain("s2", 40);
        check_grants("s2", '{0, 1, 2, 3, 0});
        check_data("s2", '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01});
        for (int i = 1; i < obs_cyc.size(); i++) begin
            check($sformatf("s2_gap%0d", i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd2);
        end

        // MAX_BURST forced rotation.
        reset_dut();
        for (int i = 0; i < 10; i++) q[1].push_back({1'b0, 8'(8'h10 + i)});
        q[3].push_back({1'b1, 8'h30});
        drain("s3", 60);
        check_grants("s3", '{1, 3, 1, 1});
        check_data("s3", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h14, 8'h15,
                           8'h16, 8'h17, 8'h18, 8'h19});

        // Sink backpressure mid-burst.
        reset_dut();
        for (int i = 0; i < 5; i++) q[0].push_back({i == 4, 8'(8'h40 + i)});
        for (int n = 0; n < 20 && obs_data.size() < 2; n++) step();
        check("s4_pre_beats", 32'(obs_data.size()), 32'd2);
        stream_in_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("s4_hold_data",  32'(stream_in_data), 32'h42);
            check("s4_hold_ready", 32'(req_ready),      32'd0);
            check("s4_hold_busy",  32'(busy),           32'd1);
            check("s4_hold_grant", 32'(grant_id),       32'd0);
        end
        stream_in_ready = 1'b1;
        drain("s4", 30);
        check_grants("s4", '{0, 0});
        check_data("s4", '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44});

        // Reset during beat 2 of a burst.
        reset_dut();
        q[2].push_back({1'b0, 8'h50});
        q[2].push_back({1'b0, 8'h51});
        q[2].push_back({1'b0, 8'h52});
        q[2].push_back({1'b1, 8'h53});
        for (int n = 0; n < 20 && obs_data.size() < 1; n++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s5_busy",  32'(busy),            32'd0);
        check("s5_grant", 32'(grant_id),        32'd0);
        check("s5_ready", 32'(req_ready),       32'd0);
        check("s5_valid", 32'(stream_in_valid), 32'd0);
        clear_logs();
        q[1].push_back({1'b1, 8'h60});
        drain("s5", 30);
        check_grants("s5", '{1, 2});
        check_data("s5", '{8'h60, 8'h51, 8'h52, 8'h53});

`ifdef STREAM_RR_ARBITER_STATS_EN
        // Five grants, then saturation from a preloaded count.
        reset_dut();
        for (int i = 0; i < 5; i++) q[i % N].push_back({1'b1, 8'(i)});
        drain("st", 40);
        check("st_count5", 32'(grant_count), 32'd5);
        dut.grant_count = 16'hFFFD;
        m_gcount        = 65533;
        for (int i = 0; i < 4; i++) q[i].push_back({1'b1, 8'(i)});
        drain("st_sat", 40);
        check("st_saturate", 32'(grant_count), 32'hFFFF);
`endif

        // Randomized traffic against the model.
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
                    q[i].push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
                end
                mute[i] = ($urandom_range(0, 9) == 0);
            end
            stream_in_ready = ($urandom_range(0, 3) != 0);
            reset           = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        mute  = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
